shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 104 ++++++++++
 tb/tb_shift_add_multiplier.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one (WIDTH+1)-bit add per clock,
// producing a 2*WIDTH-bit product after WIDTH RUN cycles.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    count_d   = count_q;
    product_d = product_q;

    // Adder stage with cin tied low; the extra bit is the carry-out.
    addend  = q_q[0] ? a_q : '0;
    sum_ext = {1'b0, acc_q} + {1'b0, addend};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // {ACC,Q} <= {c,S,Q} >> 1
        acc_d   = sum_ext[WIDTH:1];
        q_d     = {sum_ext[0], q_q[WIDTH-1:1]};
        carry_d = sum_ext[WIDTH];
        count_d = count_q + CntW'(1);
        if (count_q == CntLast) begin
          product_d = {acc_d, q_d};
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign product = product_q;
  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH=8).
module tb_shift_add_multiplier;

  localparam int unsigned WIDTH = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  int nvec;
  int nfail;

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one multiply and steps until done is seen or the bound expires.
  // Returns with time at 1ns after the edge that raised done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int busy_cycles, output bit got_done);
    busy_cycles  = 0;
    got_done     = 1'b0;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    step();
    start        = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    #12;
    nvec++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      nfail++;
      $display("FAIL reset_state: product=%h busy=%b done=%b want 0000/0/0", product, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int bc;
    bit gd;
    run_op(8'd15, 8'd15, bc, gd);
    nvec++;
    if (!gd) begin
      nfail++;
      $display("FAIL basic_timeout: done not seen");
    end
    nvec++;
    if (bc !== 8) begin
      nfail++;
      $display("FAIL basic_busy_cycles: got %0d want 8", bc);
    end
    nvec++;
    if (product !== 16'h00E1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL basic_product: got %h busy=%b want 00e1 busy=0", product, busy);
    end
    step();
    nvec++;
    if (done !== 1'b0) begin
      nfail++;
      $display("FAIL basic_done_pulse: done=%b want 0 one cycle after", done);
    end
    step();
    step();
    nvec++;
    if (product !== 16'h00E1) begin
      nfail++;
      $display("FAIL basic_hold: got %h want 00e1", product);
    end
  endtask

  task automatic test_async_reset();
    // product is 0x00E1 here; reset between edges must clear it without a clock
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    nvec++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: product=%h busy=%b done=%b want 0000/0/0", product, busy, done);
    end
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_vectors();
    logic [7:0]  av [3];
    logic [7:0]  bv [3];
    logic [15:0] pv [3];
    int bc;
    bit gd;
    av[0] = 8'd255; bv[0] = 8'd255; pv[0] = 16'hFE01;
    av[1] = 8'd0;   bv[1] = 8'd170; pv[1] = 16'h0000;
    av[2] = 8'd135; bv[2] = 8'd121; pv[2] = 16'h3FCF;
    for (int i = 0; i < 3; i++) begin
      multiplicand = av[i];
      multiplier   = bv[i];
      start        = 1'b1;
      step();
      start        = 1'b0;
      // previous result must stay visible while the new one is in flight
      if (i > 0) begin
        nvec++;
        if (product !== pv[i-1]) begin
          nfail++;
          $display("FAIL vec%0d_hold_in_run: got %h want %h", i, product, pv[i-1]);
        end
      end
      bc = 1;
      gd = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (done) begin
          gd = 1'b1;
          break;
        end
        if (busy) bc++;
      end
      nvec++;
      if (!gd || bc !== 8) begin
        nfail++;
        $display("FAIL vec%0d_latency: done=%b busy_cycles=%0d want 1/8", i, gd, bc);
      end
      nvec++;
      if (product !== pv[i]) begin
        nfail++;
        $display("FAIL vec%0d_product: %0d*%0d got %h want %h", i, av[i], bv[i], product, pv[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    // Accepts at k=0,10,20; done visible at k=8,18,28
    multiplicand = 8'd10;
    multiplier   = 8'd5;
    start        = 1'b1;
    step();
    for (int k = 0; k < 30; k++) begin
      if (k % 10 == 2) begin
        multiplicand = 8'hA7;
        multiplier   = 8'h3C;
      end
      if (k % 10 == 6) begin
        multiplicand = 8'd10;
        multiplier   = 8'd5;
      end
      if (k == 29) start = 1'b0;
      nvec++;
      if (done !== (k % 10 == 8)) begin
        nfail++;
        $display("FAIL b2b_done_k%0d: done=%b want %b", k, done, (k % 10 == 8));
      end
      if (k % 10 == 8) begin
        nvec++;
        if (product !== 16'd50) begin
          nfail++;
          $display("FAIL b2b_product_k%0d: got %0d want 50", k, product);
        end
      end
      step();
    end
    start = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid_run();
    int bc;
    bit gd;
    bit saw_done;
    multiplicand = 8'd165;
    multiplier   = 8'd90;
    start        = 1'b1;
    step();
    start = 1'b0;
    // now in RUN cycle 1; advance to RUN cycle 4
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      nfail++;
      $display("FAIL midrun_reset: busy=%b done=%b product=%h want 0/0/0000", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    nvec++;
    if (saw_done) begin
      nfail++;
      $display("FAIL midrun_abort: busy/done seen after reset, want idle");
    end
    run_op(8'd254, 8'd1, bc, gd);
    nvec++;
    if (!gd || product !== 16'd254) begin
      nfail++;
      $display("FAIL midrun_restart: done=%b product=%0d want 1/254", gd, product);
    end
    step();
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int bc;
    bit gd;
    for (int i = 0; i < 5; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      exp = 16'(a) * 16'(b);
      run_op(a, b, bc, gd);
      nvec++;
      if (!gd || bc !== 8 || product !== exp) begin
        nfail++;
        $display("FAIL random%0d: %0d*%0d got %0d (done=%b busy=%0d) want %0d",
                 i, a, b, product, gd, bc, exp);
      end
      step();
    end
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    test_reset();
    test_basic();
    test_async_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
